// File: rtl/r_cpu.sv
// r_cpu: single-cycle RV64I core executing only R-type integer ops.
// PC register, fixed instruction ROM, decoder, 64-bit ALU and 32x64 register file.
// Optional debug outputs are enabled by defining R_CPU_DEBUG_PORT_EN.

// Register file: x0 reads as zero, writes land on the clock edge, so a read
// in the same cycle as a write returns the old value.
module r_cpu_regfile #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_we,
    input  logic [XLEN-1:0] i_rd_data,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data
);

    logic [XLEN-1:0] registers [0:31];

    // Reset loads xi = i; otherwise write back the retiring result (x0 never written)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= XLEN'(i);
            end
        end else if (i_we && (i_rd_addr != 5'd0)) begin
            registers[i_rd_addr] <= i_rd_data;
        end
    end

    assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : registers[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : registers[i_rs2_addr];

endmodule

module r_cpu #(
    parameter int XLEN      = 64,
    parameter int ROM_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst
`ifdef R_CPU_DEBUG_PORT_EN
    ,
    output logic [XLEN-1:0] dbg_pc,
    output logic            dbg_wb_valid,
    output logic [XLEN-1:0] dbg_wb_data
`endif
);

    localparam int              AW      = $clog2(ROM_DEPTH);
    localparam int              SHW     = $clog2(XLEN);
    localparam logic [XLEN-1:0] PC_LAST = XLEN'((ROM_DEPTH - 1) * 4);
    localparam logic [6:0]      OP_REG  = 7'b0110011;

    logic [XLEN-1:0]        pc_out;
    logic [31:0]            instruction;
    logic [4:0]             rd;
    logic [4:0]             w_rs1;
    logic [4:0]             w_rs2;
    logic [2:0]             w_funct3;
    logic [6:0]             w_funct7;
    logic [6:0]             w_opcode;
    logic                   invalid;
    logic [XLEN-1:0]        alu_result;
    logic [XLEN-1:0]        w_rs1_val;
    logic [XLEN-1:0]        w_rs2_val;
    logic signed [XLEN-1:0] w_rs1_s;
    logic signed [XLEN-1:0] w_rs2_s;
    logic signed [XLEN-1:0] w_sra;
    logic [SHW-1:0]         w_shamt;
    logic                   w_we;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rdst);
        return {f7, rs2, rs1, f3, rdst, OP_REG};
    endfunction

    // Fixed program; each result only depends on reset values or on results that
    // repeat identically, so wrap-around re-execution leaves the same final state.
    function automatic logic [31:0] rom_word(input logic [AW-1:0] idx);
        case (int'(idx))
            0:       return r_type(7'h00, 5'd3,  5'd2,  3'b000, 5'd1);   // add
            1:       return r_type(7'h20, 5'd6,  5'd5,  3'b000, 5'd4);   // sub
            2:       return r_type(7'h00, 5'd9,  5'd8,  3'b001, 5'd7);   // sll
            3:       return r_type(7'h00, 5'd11, 5'd4,  3'b010, 5'd10);  // slt
            4:       return r_type(7'h00, 5'd14, 5'd4,  3'b011, 5'd13);  // sltu
            5:       return r_type(7'h00, 5'd18, 5'd17, 3'b100, 5'd16);  // xor
            6:       return r_type(7'h00, 5'd2,  5'd20, 3'b101, 5'd19);  // srl
            7:       return r_type(7'h20, 5'd23, 5'd4,  3'b101, 5'd22);  // sra
            8:       return r_type(7'h00, 5'd27, 5'd26, 3'b110, 5'd25);  // or
            9:       return r_type(7'h00, 5'd30, 5'd29, 3'b111, 5'd28);  // and
            10:      return 32'h0000_0013;                              // addi: not supported
            default: return 32'h0000_0000;
        endcase
    endfunction

    // PC advances one word per cycle and wraps at the end of the ROM
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out <= '0;
        end else if (pc_out >= PC_LAST) begin
            pc_out <= '0;
        end else begin
            pc_out <= pc_out + XLEN'(4);
        end
    end

    assign instruction = rom_word(pc_out[AW+1:2]);
    assign w_opcode    = instruction[6:0];
    assign rd          = instruction[11:7];
    assign w_funct3    = instruction[14:12];
    assign w_rs1       = instruction[19:15];
    assign w_rs2       = instruction[24:20];
    assign w_funct7    = instruction[31:25];

    // Only base-integer R-type encodings are legal; everything else is flagged invalid
    always_comb begin
        invalid = 1'b1;
        if (w_opcode == OP_REG) begin
            if (w_funct7 == 7'b0000000) begin
                invalid = 1'b0;
            end else if ((w_funct7 == 7'b0100000) &&
                         ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
                invalid = 1'b0;
            end
        end
    end

    r_cpu_regfile #(.XLEN(XLEN)) reg_file_inst (
        .clk        (clk),
        .rst        (rst),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .i_rd_addr  (rd),
        .i_we       (w_we),
        .i_rd_data  (alu_result),
        .o_rs1_data (w_rs1_val),
        .o_rs2_data (w_rs2_val)
    );

    assign w_rs1_s = w_rs1_val;
    assign w_rs2_s = w_rs2_val;
    assign w_shamt = w_rs2_val[SHW-1:0];
    // Arithmetic shift kept on its own signed net so the shift stays sign-filling
    assign w_sra   = w_rs1_s >>> w_shamt;

    // ALU: funct7[5] selects sub/sra; invalid instructions produce zero
    always_comb begin
        alu_result = '0;
        if (!invalid) begin
            case (w_funct3)
                3'b000:  alu_result = w_funct7[5] ? (w_rs1_val - w_rs2_val) : (w_rs1_val + w_rs2_val);
                3'b001:  alu_result = w_rs1_val << w_shamt;
                3'b010:  alu_result = {{(XLEN-1){1'b0}}, (w_rs1_s < w_rs2_s)};
                3'b011:  alu_result = {{(XLEN-1){1'b0}}, (w_rs1_val < w_rs2_val)};
                3'b100:  alu_result = w_rs1_val ^ w_rs2_val;
                3'b101:  alu_result = w_funct7[5] ? w_sra : (w_rs1_val >> w_shamt);
                3'b110:  alu_result = w_rs1_val | w_rs2_val;
                default: alu_result = w_rs1_val & w_rs2_val;
            endcase
        end
    end

    // Retire: write only for valid, non-x0 destinations outside reset
    assign w_we = !rst && !invalid && (rd != 5'd0);

`ifdef R_CPU_DEBUG_PORT_EN
    assign dbg_pc       = pc_out;
    assign dbg_wb_valid = w_we;
    assign dbg_wb_data  = alu_result;
`endif

endmodule

// File: tb/tb_r_cpu.sv
// Bench for r_cpu: table of per-PC expectations, scoreboard queue of pending
// writebacks, and a register-file model compared after every clock edge.
module tb_r_cpu;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

`ifdef R_CPU_DEBUG_PORT_EN
    logic [63:0] dbg_pc;
    logic        dbg_wb_valid;
    logic [63:0] dbg_wb_data;
    r_cpu dut (.clk(clk), .rst(rst), .dbg_pc(dbg_pc), .dbg_wb_valid(dbg_wb_valid), .dbg_wb_data(dbg_wb_data));
`else
    r_cpu dut (.clk(clk), .rst(rst));
`endif

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        inv;
        logic [63:0] res;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [63:0] val;
    } wb_t;

    vec_t        tbl [16];
    wb_t         sbq [$];
    logic [63:0] model [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 64'(i);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s x%0d", tag, i), dut.reg_file_inst.registers[i], model[i]);
    endtask

    // One instruction: check decode/ALU before the edge, push expected writeback,
    // then pop it after the edge and compare the whole register file.
    task automatic run_cycle();
        vec_t        v;
        wb_t         w;
        logic [63:0] pc;
        @(negedge clk);
        pc = dut.pc_out;
        v  = tbl[pc[5:2]];
        chk($sformatf("pc%0h instr", pc), 64'(dut.instruction), 64'(v.instr));
        chk($sformatf("pc%0h invalid", pc), 64'(dut.invalid), 64'(v.inv));
        chk($sformatf("pc%0h rd", pc), 64'(dut.rd), 64'(v.rd));
        chk($sformatf("pc%0h alu", pc), dut.alu_result, v.res);
        if (!v.inv && v.rd != 5'd0)
            chk($sformatf("pc%0h old x%0d", pc, v.rd), dut.reg_file_inst.registers[v.rd], model[v.rd]);
        w.rd = v.rd; w.we = !v.inv && (v.rd != 5'd0); w.val = v.res;
        sbq.push_back(w);
        @(posedge clk);
        #1;
        w = sbq.pop_front();
        if (w.we) model[w.rd] = w.val;
        check_regs($sformatf("after pc%0h", pc));
        chk($sformatf("pc after %0h", pc), dut.pc_out, (pc == 64'h3C) ? 64'h0 : pc + 64'd4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          budget;
        logic [63:0] exp_final [32];

        tbl[0]  = '{32'h003100B3, 5'd1,  1'b0, 64'd5};
        tbl[1]  = '{32'h40628233, 5'd4,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[2]  = '{32'h009413B3, 5'd7,  1'b0, 64'd4096};
        tbl[3]  = '{32'h00B22533, 5'd10, 1'b0, 64'd1};
        tbl[4]  = '{32'h00E236B3, 5'd13, 1'b0, 64'd0};
        tbl[5]  = '{32'h0128C833, 5'd16, 1'b0, 64'd3};
        tbl[6]  = '{32'h002A59B3, 5'd19, 1'b0, 64'd5};
        tbl[7]  = '{32'h41725B33, 5'd22, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[8]  = '{32'h01BD6CB3, 5'd25, 1'b0, 64'd27};
        tbl[9]  = '{32'h01EEFE33, 5'd28, 1'b0, 64'd28};
        tbl[10] = '{32'h00000013, 5'd0,  1'b1, 64'd0};
        for (int i = 11; i < 16; i++) tbl[i] = '{32'h0, 5'd0, 1'b1, 64'd0};

        // Reset for one cycle
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        chk("reset pc", dut.pc_out, 64'h0);
        chk("reset instr", 64'(dut.instruction), 64'h003100B3);
        chk("reset x5", dut.reg_file_inst.registers[5], 64'd5);
        chk("reset x0", dut.reg_file_inst.registers[0], 64'd0);
        check_regs("reset");

        // First ten instructions
        for (int k = 0; k < 10; k++) run_cycle();
        for (int i = 0; i < 32; i++) exp_final[i] = 64'(i);
        exp_final[1]  = 64'd5;   exp_final[4]  = '1;      exp_final[7]  = 64'd4096;
        exp_final[10] = 64'd1;   exp_final[13] = 64'd0;   exp_final[16] = 64'd3;
        exp_final[19] = 64'd5;   exp_final[22] = '1;      exp_final[25] = 64'd27;
        exp_final[28] = 64'd28;
        for (int i = 0; i < 32; i++)
            chk($sformatf("10cyc x%0d", i), dut.reg_file_inst.registers[i], exp_final[i]);

        // Ten more: covers the addi/zero words and the 0x3C -> 0x00 wrap
        for (int k = 0; k < 10; k++) run_cycle();
        for (int i = 0; i < 32; i++)
            chk($sformatf("20cyc x%0d", i), dut.reg_file_inst.registers[i], exp_final[i]);

        // Advance to PC 0x0C for the mid-run reset
        budget = 32;
        while (dut.pc_out != 64'h0C && budget > 0) begin
            run_cycle();
            budget--;
        end
        chk("reach pc 0x0C", dut.pc_out, 64'h0C);

        @(negedge clk);
        chk("inflight slt invalid", 64'(dut.invalid), 64'd0);
        chk("inflight slt rd", 64'(dut.rd), 64'd10);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        chk("midreset pc", dut.pc_out, 64'h0);
        chk("midreset x4", dut.reg_file_inst.registers[4], 64'd4);
        chk("midreset x10", dut.reg_file_inst.registers[10], 64'd10);
        check_regs("midreset");

        // Re-run add then sub: x4 must still read 4 before the sub's edge
        run_cycle();
        run_cycle();
        chk("post sub x4", dut.reg_file_inst.registers[4], 64'hFFFF_FFFF_FFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
